flog2_pipe: RTL and testbench

Multi-lane, 2-stage pipelined floor-log2 / leading-one detector with valid/ready handshake, for log-domain quantisation in the accelerator datapath. Each cycle it accepts NUM_LANES unsigned operands and returns, per lane, floor(log2(x)) plus a zero flag. Stage 1 encodes fixed-size groups; stage 2 selects the highest non-empty group. Full throughput at the default parameters.

---
 rtl/flog2_pipe_pkg.sv | 14 +
 rtl/flog2_group_enc.sv | 15 +
 rtl/flog2_pipe.sv | 97 +++++++++
 tb/tb_flog2_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/flog2_pipe_pkg.sv
// flog2_pipe_pkg: width helpers and per-lane result type shared by flog2_pipe
package flog2_pipe_pkg;
  function automatic int log_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  function automatic int num_groups(input int bw, input int gw);
    return bw / gw;
  endfunction
  typedef struct packed {
    logic [3:0] log;
    logic       zero;
    logic [2:0] frac;
  } lane_res_t;
endpackage

// File: rtl/flog2_group_enc.sv
// flog2_group_enc: one-group leading-one encoder (bits -> any set, index of highest set bit)
module flog2_group_enc #(
  parameter int GW = 4,
  parameter int IW = 2
) (
  input  logic [GW-1:0] bits,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    any = |bits;
    idx = '0;
    for (int i = 0; i < GW; i++) idx = bits[i] ? IW'(i) : idx;
  end
endmodule

// File: rtl/flog2_pipe.sv
// flog2_pipe: NUM_LANES x floor(log2) + zero flag, 2-stage valid/ready pipe; clk, rst, in_valid/in_ready/in_data -> out_valid/out_ready/out_log/out_zero/out_frac; FLOG2_FRAC_EN drives out_frac
module flog2_pipe
  import flog2_pipe_pkg::*;
#(
  parameter  int BIT_WIDTH   = 16,
  parameter  int NUM_LANES   = 4,
  parameter  int GROUP_WIDTH = 4,
  parameter  int FRAC_BITS   = 3,
  localparam int LOG_W       = log_w(BIT_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANES*BIT_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*LOG_W-1:0]     out_log,
  output logic [NUM_LANES-1:0]           out_zero,
  output logic [NUM_LANES*FRAC_BITS-1:0] out_frac
);
  localparam int NG = num_groups(BIT_WIDTH, GROUP_WIDTH);
  localparam int IW = log_w(GROUP_WIDTH);
  localparam int NS = NUM_LANES * NG;
  logic                           s1_valid_q, s2_valid_q, adv1, adv2;
  logic [NS-1:0]                  any_d, any_q;
  logic [NS*IW-1:0]               idx_d, idx_q;
  logic [NUM_LANES*LOG_W-1:0]     log_d, log_q;
  logic [NUM_LANES-1:0]           zero_d, zero_q;
  logic [NUM_LANES*FRAC_BITS-1:0] frac_d, frac_q;
  assign adv2      = s1_valid_q & (~s2_valid_q | out_ready);
  assign adv1      = in_valid & in_ready;
  assign in_ready  = ~s1_valid_q | adv2;
  assign out_valid = s2_valid_q;
  assign out_log   = log_q;
  assign out_zero  = zero_q;
  assign out_frac  = frac_q;
  for (genvar s = 0; s < NS; s++) begin : g_enc
    flog2_group_enc #(.GW(GROUP_WIDTH), .IW(IW)) u_enc (
      .bits(in_data[s*GROUP_WIDTH +: GROUP_WIDTH]),
      .any (any_d[s]),
      .idx (idx_d[s*IW +: IW])
    );
  end
  always_comb begin
    log_d  = '0;
    zero_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      zero_d[l] = ~|any_q[l*NG +: NG];
      for (int g = 0; g < NG; g++)
        log_d[l*LOG_W +: LOG_W] = any_q[l*NG+g]
          ? LOG_W'(g*GROUP_WIDTH + int'(idx_q[(l*NG+g)*IW +: IW]))
          : log_d[l*LOG_W +: LOG_W];
    end
  end
`ifdef FLOG2_FRAC_EN
  logic [NUM_LANES*BIT_WIDTH-1:0] op_q;
  always_ff @(posedge clk) begin
    if (adv1) op_q <= in_data;
  end
  always_comb begin
    int p;
    p      = 0;
    frac_d = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int k = 0; k < FRAC_BITS; k++) begin
        p = int'(log_d[l*LOG_W +: LOG_W]) - 1 - k;
        frac_d[l*FRAC_BITS + FRAC_BITS-1-k] = (p >= 0) ? op_q[l*BIT_WIDTH + p] : 1'b0;
      end
  end
`else
  assign frac_d = '0;
`endif
  always_ff @(posedge clk) begin
    if (adv1) begin
      any_q <= any_d;
      idx_q <= idx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      log_q      <= '0;
      zero_q     <= '0;
      frac_q     <= '0;
    end else begin
      s1_valid_q <= adv1 | (s1_valid_q & ~adv2);
      s2_valid_q <= adv2 | (s2_valid_q & ~out_ready);
      if (adv2) begin
        log_q  <= log_d;
        zero_q <= zero_d;
        frac_q <= frac_d;
      end
    end
  end
endmodule

// File: tb/tb_flog2_pipe.sv
// tb_flog2_pipe: randomized and directed checks of flog2_pipe against a floor-log2 reference model
module tb_flog2_pipe;
  localparam int BW = 16, NL = 4, LW = 4, FB = 3;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, sw_v = 0;
  logic [NL*BW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [NL*LW-1:0] out_log;
  logic [NL-1:0] out_zero;
  logic [NL*FB-1:0] out_frac;
  logic [7:0] s8_d = '0;
  logic [31:0] s32_d = '0;
  logic s8_ready, s8_valid, s8_zero, s32_ready, s32_valid, s32_zero;
  logic [2:0] s8_log, s8_frac, s32_frac;
  logic [4:0] s32_log;
  int n_vec = 0, n_err = 0, cyc = 0;
  bit ev;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  flog2_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_log(out_log), .out_zero(out_zero), .out_frac(out_frac)
  );
  flog2_pipe #(.BIT_WIDTH(8), .NUM_LANES(1), .GROUP_WIDTH(8)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(s8_ready), .in_data(s8_d),
    .out_valid(s8_valid), .out_ready(1'b1), .out_log(s8_log), .out_zero(s8_zero), .out_frac(s8_frac)
  );
  flog2_pipe #(.BIT_WIDTH(32), .NUM_LANES(1), .GROUP_WIDTH(2)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(sw_v), .in_ready(s32_ready), .in_data(s32_d),
    .out_valid(s32_valid), .out_ready(1'b1), .out_log(s32_log), .out_zero(s32_zero), .out_frac(s32_frac)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int mlog(input logic [63:0] x);
    int r = 0;
    for (int i = 0; i < 64; i++) if (x[i]) r = i;
    return r;
  endfunction
  function automatic logic [63:0] mfrac(input logic [63:0] x);
    return (x == 0) ? 64'd0 : ((x << FB) >> mlog(x)) & 64'((1 << FB) - 1);
  endfunction
  function automatic logic [63:0] efr(input logic [63:0] x);
`ifdef FLOG2_FRAC_EN
    return mfrac(x);
`else
    return (x == 0) ? 64'd0 : 64'd0;
`endif
  endfunction
  function automatic logic [NL*LW-1:0] elog(input logic [NL*BW-1:0] d);
    logic [NL*LW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*LW +: LW] = LW'(mlog(64'(d[l*BW +: BW])));
    return r;
  endfunction
  function automatic logic [NL-1:0] ezero(input logic [NL*BW-1:0] d);
    logic [NL-1:0] r;
    for (int l = 0; l < NL; l++) r[l] = (d[l*BW +: BW] == '0);
    return r;
  endfunction
  function automatic logic [NL*FB-1:0] efrac(input logic [NL*BW-1:0] d);
    logic [NL*FB-1:0] r;
    for (int l = 0; l < NL; l++) r[l*FB +: FB] = FB'(efr(64'(d[l*BW +: BW])));
    return r;
  endfunction
  typedef struct { logic [NL*BW-1:0] d; int t; } beat_t;
  typedef struct { logic [31:0] x; int t; } sw_t;
  beat_t q[$];
  sw_t q8[$], q32[$];
  logic prev_stall = 0;
  logic [NL*LW-1:0] prev_log;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 0;
    end else begin
      ev = q.size() > 0 && cyc >= q[0].t + 1;
      check("out_valid", out_valid, ev);
      check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (prev_stall) check("stall_hold", out_log, prev_log);
      if (ev) begin
        check("log", out_log, elog(q[0].d));
        check("zero", out_zero, ezero(q[0].d));
        check("frac", out_frac, efrac(q[0].d));
        if (out_ready) void'(q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_log   = out_log;
      if (in_valid && in_ready) q.push_back('{in_data, cyc + 1});
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      q32.delete();
    end else begin
      check("s8_ready", s8_ready, 1);
      check("s32_ready", s32_ready, 1);
      if (q8.size() > 0 && cyc >= q8[0].t + 1) begin
        check("s8_valid", s8_valid, 1);
        check("s8_log", s8_log, mlog(64'(q8[0].x)));
        check("s8_zero", s8_zero, q8[0].x == 0);
        check("s8_frac", s8_frac, efr(64'(q8[0].x)));
        void'(q8.pop_front());
      end else check("s8_valid", s8_valid, 0);
      if (q32.size() > 0 && cyc >= q32[0].t + 1) begin
        check("s32_valid", s32_valid, 1);
        check("s32_log", s32_log, mlog(64'(q32[0].x)));
        check("s32_zero", s32_zero, q32[0].x == 0);
        check("s32_frac", s32_frac, efr(64'(q32[0].x)));
        void'(q32.pop_front());
      end else check("s32_valid", s32_valid, 0);
      if (sw_v) begin
        q8.push_back('{32'(s8_d), cyc + 1});
        q32.push_back('{s32_d, cyc + 1});
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rand_data();
    logic [BW-1:0] v;
    for (int l = 0; l < NL; l++) begin
      v = BW'($urandom) >> $urandom_range(0, BW);
      in_data[l*BW +: BW] = ($urandom_range(0, 7) == 0) ? '0 : v;
    end
  endtask
  initial begin
    logic [31:0] v32;
    logic [7:0] v8;
    rst = 1;
    repeat (3) step();
    rst = 0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_log", out_log, 0);
    check("rst_zero", out_zero, 0);
    check("rst_frac", out_frac, 0);
    step();
    in_data  = {16'h00F0, 16'h8000, 16'h0001, 16'h0000};
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    @(negedge clk);
    check("dir_valid", out_valid, 1);
    check("dir_log", out_log, 16'h7F00);
    check("dir_zero", out_zero, 4'b0001);
    step();
    in_data  = {16'h0003, 16'h0002, 16'h00B0, 16'h0000};
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    @(negedge clk);
    check("dir2_log", out_log, 16'h1170);
`ifdef FLOG2_FRAC_EN
    check("dir2_frac", out_frac, 12'h818);
`else
    check("dir2_frac", out_frac, 12'h000);
`endif
    step();
    out_ready = 1;
    in_valid  = 1;
    repeat (256) begin
      rand_data();
      step();
    end
    repeat (400) begin
      rand_data();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1;
    out_ready = 0;
    repeat (3) begin
      rand_data();
      step();
    end
    rst      = 1;
    in_valid = 0;
    step();
    rst       = 0;
    out_ready = 1;
    @(negedge clk);
    check("rst_flight_valid", out_valid, 0);
    step();
    repeat (50) begin
      rand_data();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 0;
    out_ready = 1;
    sw_v      = 1;
    for (int c = 0; c < 64; c++) begin
      v32 = 32'd1 << (c / 2);
      v8  = 8'd1 << ((c / 2) % 8);
      if (c % 2 == 1) begin
        v32 = v32 | ($urandom & (v32 - 1));
        v8  = v8 | (8'($urandom) & (v8 - 1));
      end
      s32_d = v32;
      s8_d  = v8;
      step();
    end
    sw_v = 0;
    repeat (10) step();
    check("drain_main", q.size(), 0);
    check("drain_s8", q8.size(), 0);
    check("drain_s32", q32.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
